serv_ifetch_buf: RTL and testbench

- Instruction-fetch stage directly upstream of the instruction decoder and immediate decoder.
- On a fetch request from the state logic it runs one Wishbone classic read on the instruction bus.
- It captures the returned word and presents it as a registered 30-bit instruction word plus a one-cycle load strobe to the decode stage.
- It hides the bus handshake and flags non-32-bit encodings and bus faults.

---
 rtl/serv_ifetch_buf.sv | 151 +++++++++++++++
 tb/tb_serv_ifetch_buf.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_ifetch_buf.sv
// serv_ifetch_buf: instruction-fetch stage ahead of decode/immdec.
// Runs one Wishbone classic read per fetch request and presents the
// captured word (bits [31:2]) with a one-cycle o_wb_en strobe. Flags
// non-32-bit encodings through o_instr_bad.
// Optional ack watchdog: define SERV_IFETCH_TIMEOUT_EN to abort fetches
// that see no ack. The abort is reported on o_fetch_err.
module serv_ifetch_buf #(
   parameter int unsigned TIMEOUT_W = 4
) (
   input  logic        clk,
   input  logic        i_rst,
   input  logic        i_fetch_req,
   input  logic [31:0] i_pc,
   output logic [31:0] o_ibus_adr,
   output logic        o_ibus_cyc,
   input  logic [31:0] i_ibus_rdt,
   input  logic        i_ibus_ack,
   output logic [29:0] o_wb_rdt,
   output logic        o_wb_en,
   output logic        o_instr_bad,
   output logic        o_fetch_err,
   output logic        o_busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   // Fetch address is held with the byte offset already cleared.
   logic [31:0] r_pc;
   logic        r_cyc;
   logic [29:0] r_wb_rdt;
   logic        r_instr_bad;

   logic        w_accept;
   logic        w_capture;
   logic        w_abort;
   logic        w_timeout;

   // State register
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next-state and transaction control decode
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_fetch_req) begin
               w_accept    = 1'b1;
               w_state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (i_ibus_ack) begin
               w_capture   = 1'b1;
               w_state_nxt = DONE;
            end else if (w_timeout) begin
               w_abort     = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         DONE: begin
            if (i_fetch_req) begin
               w_accept    = 1'b1;
               w_state_nxt = BUSY;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Bus cycle, fetch address and captured instruction registers
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_pc        <= '0;
         r_cyc       <= 1'b0;
         r_wb_rdt    <= '0;
         r_instr_bad <= 1'b0;
      end else begin
         if (w_accept) begin
            r_pc  <= i_pc & 32'hFFFF_FFFC;
            r_cyc <= 1'b1;
         end else if (w_capture || w_abort) begin
            r_cyc <= 1'b0;
         end
         if (w_capture) begin
            r_wb_rdt    <= i_ibus_rdt[31:2];
            r_instr_bad <= (i_ibus_rdt[1:0] != 2'b11);
         end
      end
   end

`ifdef SERV_IFETCH_TIMEOUT_EN
   // Abort on the edge where the counter would reach all-ones. With
   // TIMEOUT_W=4 this gives 15 BUSY cycles. An ack in that cycle still wins.
   localparam logic [TIMEOUT_W-1:0] WDOG_TERM = TIMEOUT_W'((1 << TIMEOUT_W) - 2);

   logic [TIMEOUT_W-1:0] r_wdog;
   logic                 r_fetch_err;

   assign w_timeout = (r_wdog == WDOG_TERM);

   // Ack watchdog and one-cycle abort pulse
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_wdog      <= '0;
         r_fetch_err <= 1'b0;
      end else begin
         r_fetch_err <= w_abort;
         if (w_accept)
            r_wdog <= '0;
         else if (r_state == BUSY && !i_ibus_ack)
            r_wdog <= r_wdog + 1'b1;
      end
   end

   assign o_fetch_err = r_fetch_err;
`else
   assign w_timeout   = 1'b0;
   assign o_fetch_err = 1'b0;

   // Without the watchdog TIMEOUT_W has no effect. This empty block keeps
   // it referenced, so the parameter list is the same in both builds.
   if (TIMEOUT_W == 0) begin : g_no_wdog
   end
`endif

   assign o_ibus_adr  = r_pc;
   assign o_ibus_cyc  = r_cyc;
   assign o_wb_rdt    = r_wb_rdt;
   assign o_instr_bad = r_instr_bad;
   assign o_wb_en     = (r_state == DONE);
   // The abort pulse cycle is still counted as busy.
   assign o_busy      = (r_state != IDLE) | o_fetch_err;

endmodule

// File: tb/tb_serv_ifetch_buf.sv
// Directed self-checking bench for serv_ifetch_buf.
// Inputs are driven 1 ns after the rising edge and outputs are sampled on
// the falling edge. The watchdog scenarios run only when
// SERV_IFETCH_TIMEOUT_EN is defined.
module tb_serv_ifetch_buf;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_fetch_req;
   logic [31:0] i_pc;
   logic [31:0] o_ibus_adr;
   logic        o_ibus_cyc;
   logic [31:0] i_ibus_rdt;
   logic        i_ibus_ack;
   logic [29:0] o_wb_rdt;
   logic        o_wb_en;
   logic        o_instr_bad;
   logic        o_fetch_err;
   logic        o_busy;

   int n_checks = 0;
   int n_errors = 0;
   int strobes  = 0;
   int errs     = 0;

   serv_ifetch_buf #(.TIMEOUT_W(4)) dut (
      .clk         (clk),
      .i_rst       (i_rst),
      .i_fetch_req (i_fetch_req),
      .i_pc        (i_pc),
      .o_ibus_adr  (o_ibus_adr),
      .o_ibus_cyc  (o_ibus_cyc),
      .i_ibus_rdt  (i_ibus_rdt),
      .i_ibus_ack  (i_ibus_ack),
      .o_wb_rdt    (o_wb_rdt),
      .o_wb_en     (o_wb_en),
      .o_instr_bad (o_instr_bad),
      .o_fetch_err (o_fetch_err),
      .o_busy      (o_busy)
   );

   always #5 clk = ~clk;

   // Count strobes and abort pulses seen at each sample point
   always @(negedge clk) begin
      if (o_wb_en === 1'b1) strobes++;
      if (o_fetch_err === 1'b1) errs++;
   end

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      i_rst = 1'b1; i_fetch_req = 1'b0; i_pc = '0; i_ibus_rdt = '0; i_ibus_ack = 1'b0;
      #2;
      n_checks++; if (o_ibus_cyc !== 1'b0) begin n_errors++; $display("FAIL reset_cyc: got %b want 0", o_ibus_cyc); end
      n_checks++; if (o_ibus_adr !== 32'h0) begin n_errors++; $display("FAIL reset_adr: got %h want 0", o_ibus_adr); end
      n_checks++; if (o_wb_en !== 1'b0) begin n_errors++; $display("FAIL reset_wb_en: got %b want 0", o_wb_en); end
      n_checks++; if (o_wb_rdt !== 30'h0) begin n_errors++; $display("FAIL reset_wb_rdt: got %h want 0", o_wb_rdt); end
      n_checks++; if (o_instr_bad !== 1'b0) begin n_errors++; $display("FAIL reset_bad: got %b want 0", o_instr_bad); end
      n_checks++; if (o_fetch_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", o_fetch_err); end
      n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
      next_cycle();
      i_rst = 1'b0;
      next_cycle();
   endtask

   // Request at 0x104 with the ack in the third BUSY cycle
   task automatic test_basic;
      strobes = 0;
      i_fetch_req = 1'b1; i_pc = 32'h0000_0104;
      for (int k = 1; k <= 3; k++) begin
         next_cycle();
         i_fetch_req = 1'b0;
         i_ibus_ack  = (k == 3);
         i_ibus_rdt  = (k == 3) ? 32'h0050_0093 : 32'hxxxx_xxxx;
         @(negedge clk);
         n_checks++; if (o_ibus_cyc !== 1'b1) begin n_errors++; $display("FAIL basic_cyc%0d: got %b want 1", k, o_ibus_cyc); end
         n_checks++; if (o_ibus_adr !== 32'h0000_0104) begin n_errors++; $display("FAIL basic_adr%0d: got %h want 00000104", k, o_ibus_adr); end
         n_checks++; if (o_wb_en !== 1'b0) begin n_errors++; $display("FAIL basic_early_en%0d: got %b want 0", k, o_wb_en); end
         n_checks++; if (o_busy !== 1'b1) begin n_errors++; $display("FAIL basic_busy%0d: got %b want 1", k, o_busy); end
      end
      next_cycle();
      i_ibus_ack = 1'b0; i_ibus_rdt = 32'hxxxx_xxxx;
      @(negedge clk);
      n_checks++; if (o_wb_en !== 1'b1) begin n_errors++; $display("FAIL basic_wb_en: got %b want 1", o_wb_en); end
      n_checks++; if (o_wb_rdt !== 30'h0014_0024) begin n_errors++; $display("FAIL basic_wb_rdt: got %h want 00140024", o_wb_rdt); end
      n_checks++; if (o_instr_bad !== 1'b0) begin n_errors++; $display("FAIL basic_bad: got %b want 0", o_instr_bad); end
      n_checks++; if (o_ibus_cyc !== 1'b0) begin n_errors++; $display("FAIL basic_cyc_drop: got %b want 0", o_ibus_cyc); end
      n_checks++; if (o_busy !== 1'b1) begin n_errors++; $display("FAIL basic_busy_done: got %b want 1", o_busy); end
      next_cycle();
      @(negedge clk);
      n_checks++; if (o_wb_en !== 1'b0) begin n_errors++; $display("FAIL basic_en_after: got %b want 0", o_wb_en); end
      n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL basic_busy_idle: got %b want 0", o_busy); end
      n_checks++; if (o_wb_rdt !== 30'h0014_0024) begin n_errors++; $display("FAIL basic_rdt_hold: got %h want 00140024", o_wb_rdt); end
      n_checks++; if (strobes !== 1) begin n_errors++; $display("FAIL basic_strobes: got %0d want 1", strobes); end
   endtask

   // Zero-wait ack, then a second request issued in DONE
   task automatic test_back_to_back;
      next_cycle();
      strobes = 0;
      i_fetch_req = 1'b1; i_pc = 32'h0000_0100;
      next_cycle();
      i_fetch_req = 1'b0; i_ibus_ack = 1'b1; i_ibus_rdt = 32'h0000_0013;
      @(negedge clk);
      n_checks++; if (o_ibus_cyc !== 1'b1) begin n_errors++; $display("FAIL b2b_cyc1: got %b want 1", o_ibus_cyc); end
      n_checks++; if (o_ibus_adr !== 32'h0000_0100) begin n_errors++; $display("FAIL b2b_adr1: got %h want 00000100", o_ibus_adr); end
      next_cycle();
      i_ibus_ack = 1'b0; i_ibus_rdt = 32'hxxxx_xxxx; i_fetch_req = 1'b1; i_pc = 32'h0000_0108;
      @(negedge clk);
      n_checks++; if (o_wb_en !== 1'b1) begin n_errors++; $display("FAIL b2b_en2: got %b want 1", o_wb_en); end
      n_checks++; if (o_wb_rdt !== 30'h0000_0004) begin n_errors++; $display("FAIL b2b_rdt2: got %h want 00000004", o_wb_rdt); end
      next_cycle();
      i_fetch_req = 1'b0; i_ibus_ack = 1'b1; i_ibus_rdt = 32'h0000_0033;
      @(negedge clk);
      n_checks++; if (o_ibus_cyc !== 1'b1) begin n_errors++; $display("FAIL b2b_cyc3: got %b want 1", o_ibus_cyc); end
      n_checks++; if (o_ibus_adr !== 32'h0000_0108) begin n_errors++; $display("FAIL b2b_adr3: got %h want 00000108", o_ibus_adr); end
      n_checks++; if (o_wb_en !== 1'b0) begin n_errors++; $display("FAIL b2b_en3: got %b want 0", o_wb_en); end
      n_checks++; if (o_busy !== 1'b1) begin n_errors++; $display("FAIL b2b_busy3: got %b want 1", o_busy); end
      next_cycle();
      i_ibus_ack = 1'b0; i_ibus_rdt = 32'hxxxx_xxxx;
      @(negedge clk);
      n_checks++; if (o_wb_en !== 1'b1) begin n_errors++; $display("FAIL b2b_en4: got %b want 1", o_wb_en); end
      n_checks++; if (o_wb_rdt !== 30'h0000_000C) begin n_errors++; $display("FAIL b2b_rdt4: got %h want 0000000c", o_wb_rdt); end
      next_cycle();
      @(negedge clk);
      n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL b2b_busy5: got %b want 0", o_busy); end
      n_checks++; if (strobes !== 2) begin n_errors++; $display("FAIL b2b_strobes: got %0d want 2", strobes); end
   endtask

   // Compressed encoding, held until the next capture
   task automatic test_bad_encoding;
      next_cycle();
      i_fetch_req = 1'b1; i_pc = 32'h0000_0200;
      next_cycle();
      i_fetch_req = 1'b0; i_ibus_ack = 1'b1; i_ibus_rdt = 32'h0000_4501;
      next_cycle();
      i_ibus_ack = 1'b0; i_ibus_rdt = 32'hxxxx_xxxx;
      @(negedge clk);
      n_checks++; if (o_wb_en !== 1'b1) begin n_errors++; $display("FAIL bad_en: got %b want 1", o_wb_en); end
      n_checks++; if (o_instr_bad !== 1'b1) begin n_errors++; $display("FAIL bad_flag: got %b want 1", o_instr_bad); end
      n_checks++; if (o_wb_rdt !== 30'h0000_1140) begin n_errors++; $display("FAIL bad_rdt: got %h want 00001140", o_wb_rdt); end
      next_cycle();
      next_cycle();
      i_fetch_req = 1'b1; i_pc = 32'h0000_0204;
      next_cycle();
      i_fetch_req = 1'b0;
      @(negedge clk);
      n_checks++; if (o_instr_bad !== 1'b1) begin n_errors++; $display("FAIL bad_hold: got %b want 1", o_instr_bad); end
      next_cycle();
      i_ibus_ack = 1'b1; i_ibus_rdt = 32'h0000_0013;
      next_cycle();
      i_ibus_ack = 1'b0; i_ibus_rdt = 32'hxxxx_xxxx;
      @(negedge clk);
      n_checks++; if (o_instr_bad !== 1'b0) begin n_errors++; $display("FAIL bad_clear: got %b want 0", o_instr_bad); end
      n_checks++; if (o_wb_rdt !== 30'h0000_0004) begin n_errors++; $display("FAIL bad_rdt2: got %h want 00000004", o_wb_rdt); end
   endtask

   // Ack while idle and a request during BUSY are both ignored
   task automatic test_spurious;
      next_cycle();
      strobes = 0;
      i_ibus_ack = 1'b1; i_ibus_rdt = 32'h1234_5677;
      next_cycle();
      i_ibus_ack = 1'b0; i_ibus_rdt = 32'hxxxx_xxxx;
      @(negedge clk);
      n_checks++; if (o_wb_en !== 1'b0) begin n_errors++; $display("FAIL spur_idle_en: got %b want 0", o_wb_en); end
      n_checks++; if (o_wb_rdt !== 30'h0000_0004) begin n_errors++; $display("FAIL spur_idle_rdt: got %h want 00000004", o_wb_rdt); end
      n_checks++; if (o_ibus_cyc !== 1'b0) begin n_errors++; $display("FAIL spur_idle_cyc: got %b want 0", o_ibus_cyc); end
      i_fetch_req = 1'b1; i_pc = 32'h0000_0303;
      next_cycle();
      i_pc = 32'h0000_0400;
      next_cycle();
      i_fetch_req = 1'b0;
      @(negedge clk);
      n_checks++; if (o_ibus_adr !== 32'h0000_0300) begin n_errors++; $display("FAIL spur_adr: got %h want 00000300", o_ibus_adr); end
      next_cycle();
      i_ibus_ack = 1'b1; i_ibus_rdt = 32'h0000_0093;
      next_cycle();
      i_ibus_ack = 1'b0; i_ibus_rdt = 32'hxxxx_xxxx;
      @(negedge clk);
      n_checks++; if (o_wb_rdt !== 30'h0000_0024) begin n_errors++; $display("FAIL spur_rdt: got %h want 00000024", o_wb_rdt); end
      for (int k = 0; k < 3; k++) next_cycle();
      @(negedge clk);
      n_checks++; if (o_ibus_cyc !== 1'b0) begin n_errors++; $display("FAIL spur_cyc_end: got %b want 0", o_ibus_cyc); end
      n_checks++; if (o_ibus_adr !== 32'h0000_0300) begin n_errors++; $display("FAIL spur_adr_end: got %h want 00000300", o_ibus_adr); end
      n_checks++; if (strobes !== 1) begin n_errors++; $display("FAIL spur_strobes: got %0d want 1", strobes); end
   endtask

   // Reset while cyc is high, then a late ack after release
   task automatic test_reset_mid_busy;
      next_cycle();
      strobes = 0;
      i_fetch_req = 1'b1; i_pc = 32'h0000_0500;
      next_cycle();
      i_fetch_req = 1'b0;
      next_cycle();
      n_checks++; if (o_ibus_cyc !== 1'b1) begin n_errors++; $display("FAIL rst_pre_cyc: got %b want 1", o_ibus_cyc); end
      i_rst = 1'b1;
      #1;
      n_checks++; if (o_ibus_cyc !== 1'b0) begin n_errors++; $display("FAIL rst_async_cyc: got %b want 0", o_ibus_cyc); end
      n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL rst_async_busy: got %b want 0", o_busy); end
      n_checks++; if (o_wb_rdt !== 30'h0) begin n_errors++; $display("FAIL rst_async_rdt: got %h want 0", o_wb_rdt); end
      next_cycle();
      i_rst = 1'b0;
      next_cycle();
      i_ibus_ack = 1'b1; i_ibus_rdt = 32'h0000_0013;
      next_cycle();
      i_ibus_ack = 1'b0; i_ibus_rdt = 32'hxxxx_xxxx;
      next_cycle();
      @(negedge clk);
      n_checks++; if (strobes !== 0) begin n_errors++; $display("FAIL rst_strobes: got %0d want 0", strobes); end
      n_checks++; if (o_wb_rdt !== 30'h0) begin n_errors++; $display("FAIL rst_rdt: got %h want 0", o_wb_rdt); end
      n_checks++; if (o_ibus_adr !== 32'h0) begin n_errors++; $display("FAIL rst_adr: got %h want 0", o_ibus_adr); end
      n_checks++; if (o_ibus_cyc !== 1'b0) begin n_errors++; $display("FAIL rst_cyc: got %b want 0", o_ibus_cyc); end
   endtask

`ifdef SERV_IFETCH_TIMEOUT_EN
   // Never ack: cyc must fall after 15 BUSY cycles with one error pulse
   task automatic test_timeout;
      int cyc_cnt;
      cyc_cnt = 0;
      next_cycle();
      strobes = 0; errs = 0;
      i_fetch_req = 1'b1; i_pc = 32'h0000_0600;
      for (int k = 1; k <= 30; k++) begin
         next_cycle();
         i_fetch_req = 1'b0;
         @(negedge clk);
         if (o_ibus_cyc === 1'b1) cyc_cnt++;
      end
      n_checks++; if (cyc_cnt !== 15) begin n_errors++; $display("FAIL to_cyc_len: got %0d want 15", cyc_cnt); end
      n_checks++; if (errs !== 1) begin n_errors++; $display("FAIL to_err_pulses: got %0d want 1", errs); end
      n_checks++; if (strobes !== 0) begin n_errors++; $display("FAIL to_strobes: got %0d want 0", strobes); end
      n_checks++; if (o_wb_rdt !== 30'h0) begin n_errors++; $display("FAIL to_rdt: got %h want 0", o_wb_rdt); end
   endtask

   // Ack in the terminal-count BUSY cycle wins over the abort
   task automatic test_timeout_ack;
      next_cycle();
      strobes = 0; errs = 0;
      i_fetch_req = 1'b1; i_pc = 32'h0000_0700;
      for (int k = 1; k <= 20; k++) begin
         next_cycle();
         i_fetch_req = 1'b0;
         i_ibus_ack  = (k == 15);
         i_ibus_rdt  = (k == 15) ? 32'h0000_0093 : 32'hxxxx_xxxx;
      end
      @(negedge clk);
      n_checks++; if (strobes !== 1) begin n_errors++; $display("FAIL toack_strobes: got %0d want 1", strobes); end
      n_checks++; if (errs !== 0) begin n_errors++; $display("FAIL toack_err: got %0d want 0", errs); end
      n_checks++; if (o_wb_rdt !== 30'h0000_0024) begin n_errors++; $display("FAIL toack_rdt: got %h want 00000024", o_wb_rdt); end
   endtask
`else
   // Without the watchdog a stalled fetch must simply keep waiting
   task automatic test_no_timeout;
      next_cycle();
      errs = 0;
      i_fetch_req = 1'b1; i_pc = 32'h0000_0600;
      for (int k = 1; k <= 40; k++) begin
         next_cycle();
         i_fetch_req = 1'b0;
      end
      @(negedge clk);
      n_checks++; if (o_ibus_cyc !== 1'b1) begin n_errors++; $display("FAIL nto_cyc: got %b want 1", o_ibus_cyc); end
      n_checks++; if (errs !== 0) begin n_errors++; $display("FAIL nto_err: got %0d want 0", errs); end
      i_ibus_ack = 1'b1; i_ibus_rdt = 32'h0000_0093;
      next_cycle();
      i_ibus_ack = 1'b0; i_ibus_rdt = 32'hxxxx_xxxx;
      @(negedge clk);
      n_checks++; if (o_wb_en !== 1'b1) begin n_errors++; $display("FAIL nto_en: got %b want 1", o_wb_en); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_bad_encoding();
      test_spurious();
      test_reset_mid_busy();
`ifdef SERV_IFETCH_TIMEOUT_EN
      test_timeout();
      test_timeout_ack();
`else
      test_no_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
